// File: rtl/register_file_sb.sv
// Multi-port register file with a write-back scoreboard and a serialised post-reset clear.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module register_file_sb_rd #(
  parameter int REG_COUNT        = 32,
  parameter int DEPTH            = 32,
  parameter int ZERO_REG_IS_ZERO = 1,
`ifdef REGFILE_BYPASS_EN
  parameter int NUM_WRITE_PORTS  = 2,
`endif
  localparam int ADDR_WIDTH      = $clog2(REG_COUNT)
) (
  input  logic                            ready_i,
  input  logic [ADDR_WIDTH-1:0]           raddr_i,
  input  logic [REG_COUNT-1:0][DEPTH-1:0] regs_i,
  input  logic [REG_COUNT-1:0]            busy_i,
`ifdef REGFILE_BYPASS_EN
  input  logic [NUM_WRITE_PORTS-1:0]                 wen_i,
  input  logic [NUM_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WRITE_PORTS-1:0][DEPTH-1:0]      wdata_i,
`endif
  output logic [DEPTH-1:0]                rdata_o,
  output logic                            rbusy_o
);
  always_comb begin
    rdata_o = '0;
    rbusy_o = 1'b0;
    if (ready_i && !(ZERO_REG_IS_ZERO != 0 && raddr_i == '0) && int'(raddr_i) < REG_COUNT) begin
      rdata_o = regs_i[raddr_i];
      rbusy_o = busy_i[raddr_i];
`ifdef REGFILE_BYPASS_EN
      // ascending scan so the highest matching write port wins
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (wen_i[p] && waddr_i[p] == raddr_i) begin
          rdata_o = wdata_i[p];
          rbusy_o = 1'b0;
        end
      end
`endif
    end
  end
endmodule

module register_file_sb #(
  parameter int NUM_READ_PORTS   = 2,
  parameter int NUM_WRITE_PORTS  = 2,
  parameter int REG_COUNT        = 32,
  parameter int DEPTH            = 32,
  parameter int ZERO_REG_IS_ZERO = 1,
  localparam int ADDR_WIDTH      = $clog2(REG_COUNT)
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  output logic                                        init_done_o,
  input  logic [NUM_WRITE_PORTS-1:0]                  wen_i,
  input  logic [NUM_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  waddr_i,
  input  logic [NUM_WRITE_PORTS-1:0][DEPTH-1:0]       wdata_i,
  input  logic                                        alloc_i,
  input  logic [ADDR_WIDTH-1:0]                       alloc_addr_i,
  input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]   raddr_i,
  output logic [NUM_READ_PORTS-1:0][DEPTH-1:0]        rdata_o,
  output logic [NUM_READ_PORTS-1:0]                   rbusy_o,
  output logic [REG_COUNT-1:0]                        busy_o
);
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(REG_COUNT - 1);

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           clr_cnt_q, clr_cnt_d;
  logic                            init_done_q, init_done_d;
  logic [REG_COUNT-1:0]            busy_q, busy_d;
  logic [REG_COUNT-1:0][DEPTH-1:0] regs_q, regs_d;

  function automatic logic wr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG_IS_ZERO == 0 || a != '0) && (int'(a) < REG_COUNT);
  endfunction

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    busy_d      = busy_q;
    regs_d      = regs_q;
    case (state_q)
      CLEAR: begin
        regs_d[clr_cnt_q] = '0;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == LAST) begin
          state_d     = READY;
          init_done_d = 1'b1;
          clr_cnt_d   = '0;
        end
      end
      default: begin
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
          if (wen_i[p] && wr_ok(waddr_i[p])) begin
            regs_d[waddr_i[p]] = wdata_i[p];
            busy_d[waddr_i[p]] = 1'b0;
          end
        end
        // alloc after the write-back clear: a new producer outranks the retiring one
        if (alloc_i && wr_ok(alloc_addr_i)) busy_d[alloc_addr_i] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      regs_q      <= regs_d;
    end
  end

  assign init_done_o = init_done_q;
  assign busy_o      = busy_q;

  for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_rd
    register_file_sb_rd #(
      .REG_COUNT       (REG_COUNT),
      .DEPTH           (DEPTH),
`ifdef REGFILE_BYPASS_EN
      .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
`endif
      .ZERO_REG_IS_ZERO(ZERO_REG_IS_ZERO)
    ) u_rd (
      .ready_i (state_q == READY),
      .raddr_i (raddr_i[i]),
      .regs_i  (regs_q),
      .busy_i  (busy_q),
`ifdef REGFILE_BYPASS_EN
      .wen_i   (wen_i),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
`endif
      .rdata_o (rdata_o[i]),
      .rbusy_o (rbusy_o[i])
    );
  end
endmodule

// File: tb/tb_register_file_sb.sv
// Random + directed bench for register_file_sb; driver pushes expectations, negedge monitor checks.
module tb_register_file_sb;
  logic             clk = 1'b0;
  logic             rst;
  logic             init_done;
  logic [1:0]       wen;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;
  logic             alloc;
  logic [4:0]       alloc_addr;
  logic [1:0][4:0]  raddr;
  logic [1:0][31:0] rdata;
  logic [1:0]       rbusy;
  logic [31:0]      busy;

  always #5 clk = ~clk;

  register_file_sb dut (
    .clk_i(clk), .rst_i(rst), .init_done_o(init_done),
    .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
    .alloc_i(alloc), .alloc_addr_i(alloc_addr),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy), .busy_o(busy)
  );

  typedef struct {
    logic [1:0][31:0] rd;
    logic [1:0]       rb;
    logic [31:0]      bz;
    logic             id;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // reference model: plain arrays plus a count of clean edges since reset
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          since_rst = 0;

  function automatic exp_t model_out();
    exp_t e;
    int   a;
    e.id = (since_rst >= 32);
    e.rd = '0; e.rb = '0; e.bz = '0;
    if (e.id) begin
      for (int r = 0; r < 32; r++) e.bz[r] = m_busy[r];
      for (int i = 0; i < 2; i++) begin
        a = int'(raddr[i]);
        if (a != 0) begin
          e.rd[i] = m_regs[a];
          e.rb[i] = m_busy[a];
`ifdef REGFILE_BYPASS_EN
          for (int p = 0; p < 2; p++)
            if (wen[p] && int'(waddr[p]) == a) begin e.rd[i] = wdata[p]; e.rb[i] = 1'b0; end
`endif
        end
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    if (rst) begin
      since_rst = 0;
      for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
    end else if (since_rst < 32) begin
      since_rst++;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wen[p] && waddr[p] != 0) begin m_regs[waddr[p]] = wdata[p]; m_busy[waddr[p]] = 0; end
      if (alloc && alloc_addr != 0) m_busy[alloc_addr] = 1;
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("init_done", {31'd0, init_done}, {31'd0, e.id});
      chk("busy_o",    busy,               e.bz);
      chk("rdata0",    rdata[0],           e.rd[0]);
      chk("rdata1",    rdata[1],           e.rd[1]);
      chk("rbusy",     {30'd0, rbusy},     {30'd0, e.rb});
    end
  end

  task automatic step();
    q.push_back(model_out());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; alloc = 1'b0; alloc_addr = '0;
  endtask

  function automatic logic [4:0] raddr_pick();
    return ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  task automatic rand_in(input bit allow_rst);
    rst = allow_rst && ($urandom_range(0, 199) == 0);
    for (int p = 0; p < 2; p++) begin
      wen[p]   = ($urandom_range(0, 2) != 0);
      waddr[p] = raddr_pick();
      wdata[p] = $urandom;
    end
    alloc      = ($urandom_range(0, 1) != 0);
    alloc_addr = raddr_pick();
    raddr[0]   = raddr_pick();
    raddr[1]   = raddr_pick();
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wen[p] = 1'b1; waddr[p] = a; wdata[p] = d;
  endtask

  initial begin
    rst = 1'b1; idle(); raddr = '0;
    repeat (2) @(posedge clk);
    model_edge();
    #1;
    step();                                       // reset state
    rst = 1'b0;
    repeat (10) begin rand_in(0); step(); end     // writes/allocs ignored in CLEAR
    idle(); rst = 1'b1; step();                   // restart mid-clear
    rst = 1'b0;
    repeat (33) begin rand_in(0); step(); end
    idle(); raddr = '0;

    wr(0, 5, 32'hDEAD_BEEF); raddr[0] = 5; step();
    idle(); step();
    wr(0, 0, 32'h1234); step();
    idle(); raddr[0] = 0; step();
    wr(0, 7, 32'h11); wr(1, 7, 32'h22); step();
    idle(); raddr[0] = 7; step();
    alloc = 1'b1; alloc_addr = 9; raddr[1] = 9; step();
    idle(); step();
    wr(0, 9, 32'h99); step();
    idle(); step();
    alloc = 1'b1; alloc_addr = 9; wr(1, 9, 32'h77); step();
    idle(); step();
    alloc = 1'b1; alloc_addr = 9; step();         // alloc to already-busy
    alloc = 1'b1; alloc_addr = 0; raddr[0] = 0; step();
    idle(); raddr[1] = 3; wr(0, 3, 32'hA5); step();
    idle(); step();

    repeat (3000) begin rand_in(1); step(); end
    rst = 1'b0; idle(); step();
    @(negedge clk); #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
